// File: rtl/coherence_bus_arbiter.sv
// rtl/coherence_bus_arbiter.sv - two-cpu round-robin snooping coherence bus arbiter
module coherence_bus_arbiter #(
    parameter int SNOOP_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_miss0,
    input  logic        read_miss1,
    input  logic        write_miss0,
    input  logic        write_miss1,
    input  logic        invalidate0,
    input  logic        invalidate1,
    input  logic [10:0] BICO0,
    input  logic [10:0] BICO1,
    input  logic        cpu_search_found0,
    input  logic        cpu_search_found1,
    input  logic [15:0] send_other_proc_data0,
    input  logic [15:0] send_other_proc_data1,
    output logic        grant0,
    output logic        grant1,
    output logic        cpu_search0,
    output logic        cpu_search1,
    output logic [12:0] BOCI0,
    output logic [12:0] BOCI1,
    output logic [1:0]  cpu_datasel0,
    output logic [1:0]  cpu_datasel1,
    output logic        invalidate_from_other_cpu0,
    output logic        invalidate_from_other_cpu1,
    output logic [15:0] other_proc_data0,
    output logic [15:0] other_proc_data1
);
    typedef enum logic [2:0] {
        S_IDLE, S_SNOOP, S_RESOLVE, S_GRANT, S_RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic        r_winner;
    logic        r_last_grant;
    logic [1:0]  r_op;
    logic [10:0] r_addr;

    logic [1:0]  r_grant;
    logic [1:0]  r_search;
    logic [1:0]  r_inv;
    logic [12:0] r_boci [2];
    logic [1:0]  r_dsel [2];
    logic [15:0] r_opd  [2];

    logic [1:0]  w_grant_d;
    logic [1:0]  w_search_d;
    logic [1:0]  w_inv_d;
    logic [12:0] w_boci_d [2];
    logic [1:0]  w_dsel_d [2];
    logic [15:0] w_opd_d  [2];

    logic [1:0]  w_req;
    logic [1:0]  w_op   [2];
    logic [10:0] w_bico [2];
    logic        w_found[2];
    logic [15:0] w_send [2];
    logic        w_win;
    logic        w_cur_w;
    logic        w_cur_o;
    logic        w_other;
    logic [1:0]  w_cur_op;
    logic [10:0] w_cur_addr;
    logic [1:0]  w_dsel_calc;

    function automatic logic [1:0] f_op(input logic rm, input logic wm, input logic inv);
        if (inv)     return 2'b11;
        else if (wm) return 2'b10;
        else if (rm) return 2'b01;
        else         return 2'b00;
    endfunction

    assign w_req[0]   = read_miss0 | write_miss0 | invalidate0;
    assign w_req[1]   = read_miss1 | write_miss1 | invalidate1;
    assign w_op[0]    = f_op(read_miss0, write_miss0, invalidate0);
    assign w_op[1]    = f_op(read_miss1, write_miss1, invalidate1);
    assign w_bico[0]  = BICO0;
    assign w_bico[1]  = BICO1;
    assign w_found[0] = cpu_search_found0;
    assign w_found[1] = cpu_search_found1;
    assign w_send[0]  = send_other_proc_data0;
    assign w_send[1]  = send_other_proc_data1;

    // On a tie the cpu that did not win last time goes first.
    assign w_win      = (w_req[0] & w_req[1]) ? ~r_last_grant : w_req[1];
    assign w_cur_w    = (r_state == S_IDLE) ? w_win : r_winner;
    assign w_cur_o    = ~w_cur_w;
    assign w_other    = ~r_winner;
    assign w_cur_op   = (r_state == S_IDLE) ? w_op[w_win] : r_op;
    assign w_cur_addr = (r_state == S_IDLE) ? w_bico[w_win] : r_addr;
    assign w_dsel_calc = (r_op == 2'b11) ? 2'b00 : (w_found[w_other] ? 2'b01 : 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_winner     <= 1'b0;
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_addr       <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_next_state == S_SNOOP) begin
                        r_winner <= w_win;
                        r_op     <= w_op[w_win];
                        r_addr   <= w_bico[w_win];
                        r_cnt    <= 4'(SNOOP_LAT);
                    end
                end
                S_SNOOP: r_cnt        <= r_cnt - 4'd1;
                S_GRANT: r_last_grant <= r_winner;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (|w_req) w_next_state = S_SNOOP;
            S_SNOOP:   if (r_cnt <= 4'd1) w_next_state = S_RESOLVE;
            S_RESOLVE: w_next_state = S_GRANT;
            S_GRANT:   w_next_state = S_RELEASE;
            S_RELEASE: if (!w_req[r_winner]) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        w_grant_d  = '0;
        w_search_d = '0;
        w_inv_d    = '0;
        w_boci_d   = r_boci;
        w_dsel_d   = r_dsel;
        w_opd_d    = r_opd;
        if (w_next_state == S_IDLE) begin
            w_boci_d[0] = '0;
            w_boci_d[1] = '0;
        end else begin
            w_boci_d[0] = {w_cur_op, w_cur_addr};
            w_boci_d[1] = {w_cur_op, w_cur_addr};
        end
        if (w_next_state == S_SNOOP)
            w_search_d[w_cur_o] = 1'b1;
        if (w_next_state == S_GRANT) begin
            w_grant_d[w_cur_w] = 1'b1;
            w_inv_d[w_cur_o]   = r_op[1];
        end
        if (r_state == S_RESOLVE) begin
            w_dsel_d[r_winner] = w_dsel_calc;
            w_opd_d[r_winner]  = w_send[w_other];
        end
        if (r_state == S_RELEASE && w_next_state == S_IDLE)
            w_dsel_d[r_winner] = 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant   <= '0;
            r_search  <= '0;
            r_inv     <= '0;
            r_boci[0] <= '0;
            r_boci[1] <= '0;
            r_dsel[0] <= '0;
            r_dsel[1] <= '0;
            r_opd[0]  <= '0;
            r_opd[1]  <= '0;
        end else begin
            r_grant  <= w_grant_d;
            r_search <= w_search_d;
            r_inv    <= w_inv_d;
            r_boci   <= w_boci_d;
            r_dsel   <= w_dsel_d;
            r_opd    <= w_opd_d;
        end
    end

    assign grant0                     = r_grant[0];
    assign grant1                     = r_grant[1];
    assign cpu_search0                = r_search[0];
    assign cpu_search1                = r_search[1];
    assign invalidate_from_other_cpu0 = r_inv[0];
    assign invalidate_from_other_cpu1 = r_inv[1];
    assign BOCI0                      = r_boci[0];
    assign BOCI1                      = r_boci[1];
    assign cpu_datasel0               = r_dsel[0];
    assign cpu_datasel1               = r_dsel[1];
    assign other_proc_data0           = r_opd[0];
    assign other_proc_data1           = r_opd[1];
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// tb/tb_coherence_bus_arbiter.sv - scoreboard bench for coherence_bus_arbiter
module tb_coherence_bus_arbiter;
    localparam int LAT_A = 1;
    localparam int LAT_B = 4;

    typedef struct packed {
        int          w;
        logic [1:0]  op;
        logic [10:0] addr;
        logic [1:0]  dsel;
        logic [15:0] data;
        int          c0;
        int          g;
        int          clr;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel   = 1'b0;
    logic [1:0]  rm = '0, wm = '0, iv = '0, found = '0;
    logic [10:0] bico  [2];
    logic [15:0] sdata [2];
    int          cyc = 0, checks = 0, errors = 0, last_grant = 1;
    exp_t        q[$];
    exp_t        cur;
    bit          have_cur = 1'b0;

    logic        a_grant[2], a_search[2], a_inv[2], b_grant[2], b_search[2], b_inv[2];
    logic [12:0] a_boci[2], b_boci[2];
    logic [1:0]  a_dsel[2], b_dsel[2];
    logic [15:0] a_opd[2],  b_opd[2];
    logic        m_grant[2], m_search[2], m_inv[2];
    logic [12:0] m_boci[2];
    logic [1:0]  m_dsel[2];
    logic [15:0] m_opd[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coherence_bus_arbiter #(.SNOOP_LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .read_miss0(rm[0]), .read_miss1(rm[1]), .write_miss0(wm[0]), .write_miss1(wm[1]),
        .invalidate0(iv[0]), .invalidate1(iv[1]), .BICO0(bico[0]), .BICO1(bico[1]),
        .cpu_search_found0(found[0]), .cpu_search_found1(found[1]),
        .send_other_proc_data0(sdata[0]), .send_other_proc_data1(sdata[1]),
        .grant0(a_grant[0]), .grant1(a_grant[1]), .cpu_search0(a_search[0]), .cpu_search1(a_search[1]),
        .BOCI0(a_boci[0]), .BOCI1(a_boci[1]), .cpu_datasel0(a_dsel[0]), .cpu_datasel1(a_dsel[1]),
        .invalidate_from_other_cpu0(a_inv[0]), .invalidate_from_other_cpu1(a_inv[1]),
        .other_proc_data0(a_opd[0]), .other_proc_data1(a_opd[1])
    );

    coherence_bus_arbiter #(.SNOOP_LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .read_miss0(rm[0]), .read_miss1(rm[1]), .write_miss0(wm[0]), .write_miss1(wm[1]),
        .invalidate0(iv[0]), .invalidate1(iv[1]), .BICO0(bico[0]), .BICO1(bico[1]),
        .cpu_search_found0(found[0]), .cpu_search_found1(found[1]),
        .send_other_proc_data0(sdata[0]), .send_other_proc_data1(sdata[1]),
        .grant0(b_grant[0]), .grant1(b_grant[1]), .cpu_search0(b_search[0]), .cpu_search1(b_search[1]),
        .BOCI0(b_boci[0]), .BOCI1(b_boci[1]), .cpu_datasel0(b_dsel[0]), .cpu_datasel1(b_dsel[1]),
        .invalidate_from_other_cpu0(b_inv[0]), .invalidate_from_other_cpu1(b_inv[1]),
        .other_proc_data0(b_opd[0]), .other_proc_data1(b_opd[1])
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_grant[i]  = sel ? b_grant[i]  : a_grant[i];
            m_search[i] = sel ? b_search[i] : a_search[i];
            m_inv[i]    = sel ? b_inv[i]    : a_inv[i];
            m_boci[i]   = sel ? b_boci[i]   : a_boci[i];
            m_dsel[i]   = sel ? b_dsel[i]   : a_dsel[i];
            m_opd[i]    = sel ? b_opd[i]    : a_opd[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 2; i++) begin
            acc = acc | 32'(a_grant[i]) | 32'(a_search[i]) | 32'(a_inv[i]) | 32'(a_boci[i])
                      | 32'(a_dsel[i]) | 32'(a_opd[i]) | 32'(b_grant[i]) | 32'(b_search[i])
                      | 32'(b_inv[i]) | 32'(b_boci[i]) | 32'(b_dsel[i]) | 32'(b_opd[i]);
        end
        return acc;
    endfunction

    always @(negedge clk) begin : monitor
        int         lat;
        int         o;
        exp_t       f;
        logic [1:0] es, sv, gv, ivv;
        if (rst_n) begin
            lat = sel ? LAT_B : LAT_A;
            es  = 2'b00;
            if (q.size() > 0 && cyc >= q[0].c0 + 1 && cyc <= q[0].c0 + lat)
                es[1 - q[0].w] = 1'b1;
            sv  = {m_search[1], m_search[0]};
            gv  = {m_grant[1], m_grant[0]};
            ivv = {m_inv[1], m_inv[0]};
            chk("cpu_search", 32'(sv), 32'(es));
            if (gv != 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", 32'(gv), 32'd0);
                end else begin
                    f = q.pop_front();
                    o = 1 - f.w;
                    chk("grant_who", 32'(gv), 1 << f.w);
                    chk("grant_cycle", cyc, f.g);
                    chk("datasel", 32'(m_dsel[f.w]), 32'(f.dsel));
                    chk("other_proc_data", 32'(m_opd[f.w]), 32'(f.data));
                    chk("invalidate", 32'(ivv), f.op[1] ? (1 << o) : 0);
                    chk("boci_other", 32'(m_boci[o]), 32'({f.op, f.addr}));
                    chk("boci_req", 32'(m_boci[f.w]), 32'({f.op, f.addr}));
                    cur      = f;
                    have_cur = 1'b1;
                end
            end else begin
                chk("stray_invalidate", 32'(ivv), 32'd0);
                if (q.size() > 0 && cyc > q[0].g) begin
                    chk("grant_timeout", cyc, q[0].g);
                    void'(q.pop_front());
                end
            end
            if (have_cur && cyc > cur.g) begin
                if (cyc < cur.clr) begin
                    chk("datasel_hold", 32'(m_dsel[cur.w]), 32'(cur.dsel));
                end else begin
                    chk("datasel_clear", 32'(m_dsel[cur.w]), 32'd0);
                    chk("boci_idle", 32'(m_boci[0] | m_boci[1]), 32'd0);
                    chk("data_hold", 32'(m_opd[cur.w]), 32'(cur.data));
                    have_cur = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k = {invalidate, write_miss, read_miss}; drop_rel places the requester's drop relative to its grant
    task automatic txn(input logic [2:0] k0, input logic [2:0] k1, input logic [10:0] a0,
                       input logic [10:0] a1, input logic [1:0] f, input logic [15:0] d0,
                       input logic [15:0] d1, input int drop_rel);
        exp_t       e;
        int         lat, d, o;
        logic [2:0] kw;
        lat = sel ? LAT_B : LAT_A;
        step();
        rm = {k1[0], k0[0]};
        wm = {k1[1], k0[1]};
        iv = {k1[2], k0[2]};
        bico[0] = a0;  bico[1] = a1;
        sdata[0] = d0; sdata[1] = d1;
        found = f;
        e.c0 = cyc;
        if (k0 != 3'b000 && k1 != 3'b000) e.w = 1 - last_grant;
        else                              e.w = (k1 != 3'b000) ? 1 : 0;
        last_grant = e.w;
        o      = 1 - e.w;
        kw     = (e.w == 1) ? k1 : k0;
        e.op   = kw[2] ? 2'b11 : (kw[1] ? 2'b10 : 2'b01);
        e.addr = (e.w == 1) ? a1 : a0;
        e.dsel = (e.op == 2'b11) ? 2'b00 : (f[o] ? 2'b01 : 2'b10);
        e.data = sdata[o];
        e.g    = e.c0 + lat + 2;
        d      = e.g + drop_rel;
        if (d < e.c0 + 1) d = e.c0 + 1;
        e.clr  = ((e.g + 1 > d) ? e.g + 1 : d) + 1;
        q.push_back(e);
        step();
        if (e.w == 1) begin rm[0] = 1'b0; wm[0] = 1'b0; iv[0] = 1'b0; end
        else          begin rm[1] = 1'b0; wm[1] = 1'b0; iv[1] = 1'b0; end
        while (cyc < d) step();
        rm = '0; wm = '0; iv = '0;
        while (cyc < e.clr - 1) step();
    endtask

    task automatic rand_txn();
        logic [2:0] k0, k1;
        int         dr;
        k0 = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        k1 = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        if (k0 == 3'b000 && k1 == 3'b000) k0 = 3'($urandom_range(1, 7));
        dr = int'($urandom_range(0, 5)) - 1;
        if ($urandom_range(0, 7) == 0) dr = -100;
        txn(k0, k1, 11'($urandom), 11'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), dr);
        repeat ($urandom_range(0, 2)) step();
    endtask

    initial begin
        bico[0] = '0; bico[1] = '0; sdata[0] = '0; sdata[1] = '0;
        repeat (3) step();
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 3; i++)
            txn(3'b001, 3'b001, 11'(12'h100 + i), 11'(12'h200 + i), 2'b11, 16'h1111, 16'h2222, 1);
        txn(3'b001, 3'b000, 11'h2A5, 11'h000, 2'b10, 16'h0000, 16'hBEEF, 0);
        txn(3'b000, 3'b010, 11'h000, 11'h010, 2'b00, 16'h1234, 16'h0000, 0);
        txn(3'b100, 3'b000, 11'h155, 11'h000, 2'b10, 16'h0000, 16'h5A5A, 2);
        txn(3'b011, 3'b000, 11'h7FF, 11'h000, 2'b10, 16'h0000, 16'hCAFE, -100);

        step();
        rm = 2'b10; bico[1] = 11'h321;
        step();
        chk("snoop_before_reset", 32'(m_search[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        rm    = '0;
        #1;
        chk("reset_in_snoop", all_outs(), 32'd0);
        q.delete();
        have_cur   = 1'b0;
        last_grant = 1;
        step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        txn(3'b001, 3'b001, 11'h0F0, 11'h00F, 2'b01, 16'hAAAA, 16'h5555, 0);

        for (int i = 0; i < 40; i++) rand_txn();

        rst_n = 1'b0;
        step();
        sel = 1'b1;
        q.delete();
        have_cur   = 1'b0;
        last_grant = 1;
        step();
        rst_n = 1'b1;
        step();
        txn(3'b001, 3'b000, 11'h2A5, 11'h000, 2'b10, 16'h0000, 16'hBEEF, 4);
        for (int i = 0; i < 15; i++) rand_txn();

        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
